ps2_rx_frame: RTL and testbench

//  Receive-only PS/2 device-to-host deserializer. Synchronizes and deglitches PS2_CLK,

---
 rtl/ps2_rx_frame.sv | 125 ++++++++++++
 tb/tb_ps2_rx_frame.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - receive-only PS/2 device-to-host frame deserializer
module ps2_rx_frame #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] received_data,
    output logic       received_data_en,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic          fall;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2_CLK;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2_DAT;
            dat_s2 <= dat_s1;
        end
    end

    // filt_clk only follows the synced clock after a full run of differing samples
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt >= FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = filt_prev & ~filt_clk;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            bit_cnt          <= '0;
            shift            <= '0;
            parity_bit       <= 1'b0;
            tmo_cnt          <= '0;
            received_data    <= '0;
            received_data_en <= 1'b0;
            frame_err        <= 1'b0;
            err_code         <= 2'b00;
        end else begin
            received_data_en <= 1'b0;
            frame_err        <= 1'b0;

            if (fall || state == IDLE)
                tmo_cnt <= '0;
            else if (tmo_cnt < TW'(TIMEOUT_CYCLES - 1))
                tmo_cnt <= tmo_cnt + 1'b1;

            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        parity_bit <= dat_s2;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if ((^{shift, parity_bit}) && dat_s2) begin
                            received_data    <= shift;
                            received_data_en <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= (^{shift, parity_bit}) ? 2'b10 : 2'b01;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tmo_cnt >= TW'(TIMEOUT_CYCLES - 1)) begin
                // stalled mid-frame: drop the partial byte
                state     <= IDLE;
                frame_err <= 1'b1;
                err_code  <= 2'b11;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - directed bench for ps2_rx_frame
module tb_ps2_rx_frame;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       frame_err;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q[$];
    logic [1:0] err_q[$];
    int         both_cnt = 0;

    localparam int FAST = 40;
    localparam int SLOW = 1500;

    ps2_rx_frame dut (
        .CLOCK_50        (CLOCK_50),
        .resetn          (resetn),
        .PS2_CLK         (PS2_CLK),
        .PS2_DAT         (PS2_DAT),
        .received_data   (received_data),
        .received_data_en(received_data_en),
        .frame_err       (frame_err),
        .err_code        (err_code)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (received_data_en) rx_q.push_back(received_data);
        if (frame_err) err_q.push_back(err_code);
        if (received_data_en && frame_err) both_cnt++;
    end

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par_flip,
                                               input logic stop);
        return {stop, (~^d) ^ par_flip, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half,
                             input logic glitch);
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = bits[i];
            if (glitch) begin
                repeat (half / 2) @(posedge CLOCK_50);
                PS2_CLK = 1'b0;
                repeat (4) @(posedge CLOCK_50);
                PS2_CLK = 1'b1;
                repeat (half - half / 2 - 4) @(posedge CLOCK_50);
            end else begin
                repeat (half) @(posedge CLOCK_50);
            end
            PS2_CLK = 1'b0;
            repeat (half) @(posedge CLOCK_50);
            PS2_CLK = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                              input int half, input logic glitch);
        send_bits(make_frame(d, par_flip, stop), 11, half, glitch);
        PS2_DAT = 1'b1;
    endtask

    task automatic settle();
        repeat (60) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic clear_q();
        rx_q.delete();
        err_q.delete();
    endtask

    task automatic check_rx(input string name, input int n, input logic [7:0] v0,
                            input logic [7:0] v1);
        checks++;
        if (rx_q.size() !== n) begin
            errors++;
            $display("FAIL %s rx_count: got %0d expected %0d", name, rx_q.size(), n);
        end else begin
            if (n > 0) begin
                checks++;
                if (rx_q[0] !== v0) begin
                    errors++;
                    $display("FAIL %s byte0: got %02h expected %02h", name, rx_q[0], v0);
                end
            end
            if (n > 1) begin
                checks++;
                if (rx_q[1] !== v1) begin
                    errors++;
                    $display("FAIL %s byte1: got %02h expected %02h", name, rx_q[1], v1);
                end
            end
        end
    endtask

    task automatic check_err(input string name, input int n, input logic [1:0] code);
        checks++;
        if (err_q.size() !== n) begin
            errors++;
            $display("FAIL %s err_count: got %0d expected %0d", name, err_q.size(), n);
        end else if (n > 0) begin
            checks++;
            if (err_q[0] !== code) begin
                errors++;
                $display("FAIL %s err_code: got %b expected %b", name, err_q[0], code);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({received_data, received_data_en, frame_err, err_code} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %03h expected 000",
                     {received_data, received_data_en, frame_err, err_code});
        end
        repeat (3) @(posedge CLOCK_50);
        #3 resetn = 1'b1;
        clear_q();
        repeat (50) @(posedge CLOCK_50);
        #1;
        check_rx("reset_idle", 0, 8'h00, 8'h00);
        check_err("reset_idle", 0, 2'b00);
    endtask

    task automatic test_single();
        clear_q();
        send_frame(8'h5A, 1'b0, 1'b1, SLOW, 1'b0);
        settle();
        check_rx("single_5a", 1, 8'h5A, 8'h00);
        check_err("single_5a", 0, 2'b00);
    endtask

    task automatic test_back_to_back();
        clear_q();
        send_frame(8'hE0, 1'b0, 1'b1, FAST, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b1, FAST, 1'b0);
        settle();
        check_rx("b2b", 2, 8'hE0, 8'h6B);
        check_err("b2b", 0, 2'b00);
    endtask

    task automatic test_parity_err();
        clear_q();
        send_frame(8'h74, 1'b1, 1'b1, FAST, 1'b0);
        settle();
        check_rx("parity", 0, 8'h00, 8'h00);
        check_err("parity", 1, 2'b01);
        checks++;
        if (received_data !== 8'h6B) begin
            errors++;
            $display("FAIL parity_hold: got %02h expected 6b", received_data);
        end
        checks++;
        if (err_code !== 2'b01) begin
            errors++;
            $display("FAIL parity_code_hold: got %b expected 01", err_code);
        end
    endtask

    task automatic test_stop_err();
        clear_q();
        send_frame(8'hF0, 1'b0, 1'b0, FAST, 1'b0);
        settle();
        check_rx("stop", 0, 8'h00, 8'h00);
        check_err("stop", 1, 2'b10);
        clear_q();
        send_frame(8'h5A, 1'b0, 1'b1, FAST, 1'b0);
        settle();
        check_rx("stop_recover", 1, 8'h5A, 8'h00);
        check_err("stop_recover", 0, 2'b00);
    endtask

    task automatic test_timeout();
        clear_q();
        send_bits(make_frame(8'h03, 1'b0, 1'b1), 5, FAST, 1'b0);
        PS2_DAT = 1'b1;
        repeat (15000) @(posedge CLOCK_50);
        #1;
        check_rx("timeout", 0, 8'h00, 8'h00);
        check_err("timeout", 1, 2'b11);
        clear_q();
        send_frame(8'h6B, 1'b0, 1'b1, FAST, 1'b0);
        settle();
        check_rx("timeout_recover", 1, 8'h6B, 8'h00);
        check_err("timeout_recover", 0, 2'b00);
    endtask

    task automatic test_glitch_and_reset();
        clear_q();
        send_frame(8'h5A, 1'b0, 1'b1, FAST, 1'b1);
        settle();
        check_rx("glitch", 1, 8'h5A, 8'h00);
        check_err("glitch", 0, 2'b00);

        clear_q();
        send_bits(make_frame(8'hFF, 1'b0, 1'b1), 4, FAST, 1'b0);
        repeat (7) @(posedge CLOCK_50);
        #5 resetn = 1'b0;
        #1;
        checks++;
        if ({received_data, received_data_en, frame_err, err_code} !== 12'h000) begin
            errors++;
            $display("FAIL midframe_reset: got %03h expected 000",
                     {received_data, received_data_en, frame_err, err_code});
        end
        PS2_DAT = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #3 resetn = 1'b1;
        repeat (20) @(posedge CLOCK_50);
        clear_q();
        send_frame(8'hA5, 1'b0, 1'b1, FAST, 1'b0);
        settle();
        check_rx("after_reset", 1, 8'hA5, 8'h00);
        check_err("after_reset", 0, 2'b00);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity_err();
        test_stop_err();
        test_timeout();
        test_glitch_and_reset();
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL en_and_err_together: got %0d expected 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
